// File: rtl/display_scan_controller.sv
// Two-digit scan controller: latches a 0..15 value once per frame, splits it into
// tens/units and time-multiplexes one shared segment decoder with blanking gaps.
module display_scan_controller #(
    parameter int unsigned DWELL_CYCLES = 27000,
    parameter int unsigned BLANK_CYCLES = 16,
    parameter int unsigned LZ_BLANK     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] binary_code,
    output logic [3:0] digit,
    output logic       blank,
    output logic [1:0] an,
    output logic       frame_start
);

    localparam int unsigned CNT_MAX = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        BLANK_TO_UNITS,
        SHOW_UNITS,
        BLANK_TO_TENS,
        SHOW_TENS
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, last_cnt;
    logic [3:0]       value_q, value_n;
    logic             tens_n;
    logic [3:0]       units_n;
    logic [3:0]       digit_n;
    logic             blank_n;
    logic [1:0]       an_n;
    logic             frame_start_n;

    // Next state, counter and latched value; outputs are decoded from the next
    // registered values so they line up with the state they describe.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt + CNT_W'(1);
        value_n  = value_q;
        last_cnt = CNT_W'(DWELL_CYCLES - 1);
        if (state == BLANK_TO_UNITS || state == BLANK_TO_TENS) begin
            last_cnt = CNT_W'(BLANK_CYCLES - 1);
        end

        if (cnt == last_cnt) begin
            cnt_n = '0;
            unique case (state)
                BLANK_TO_UNITS: begin
                    state_n = SHOW_UNITS;
                    value_n = binary_code;
                end
                SHOW_UNITS:     state_n = BLANK_TO_TENS;
                BLANK_TO_TENS:  state_n = SHOW_TENS;
                SHOW_TENS:      state_n = BLANK_TO_UNITS;
            endcase
        end

        tens_n  = (value_n >= 4'd10);
        units_n = tens_n ? (value_n - 4'd10) : value_n;

        an_n          = 2'b11;
        blank_n       = 1'b1;
        digit_n       = 4'd0;
        frame_start_n = 1'b0;
        case (state_n)
            SHOW_UNITS: begin
                an_n          = 2'b10;
                blank_n       = 1'b0;
                digit_n       = units_n;
                frame_start_n = (cnt_n == '0);
            end
            SHOW_TENS: begin
                // Leading-zero tens slot still consumes its time, just dark.
                if (tens_n || LZ_BLANK == 0) begin
                    an_n    = 2'b01;
                    blank_n = 1'b0;
                    digit_n = {3'b000, tens_n};
                end
            end
            default: ;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= BLANK_TO_UNITS;
            cnt         <= '0;
            value_q     <= 4'd0;
            an          <= 2'b11;
            blank       <= 1'b1;
            digit       <= 4'd0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            value_q     <= value_n;
            an          <= an_n;
            blank       <= blank_n;
            digit       <= digit_n;
            frame_start <= frame_start_n;
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Randomized bench for display_scan_controller: two instances (leading-zero
// blanking on and off) checked every cycle against a frame-position model.
module tb_display_scan_controller;

    localparam int unsigned DWELL  = 4;
    localparam int unsigned BLANKC = 2;
    localparam int unsigned PERIOD = 2 * (DWELL + BLANKC);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] binary_code = 4'd0;

    logic [3:0] digit1, digit0;
    logic       blank1, blank0;
    logic [1:0] an1, an0;
    logic       fs1, fs0;

    int errors = 0;
    int checks = 0;
    int t      = 0;   // rising edges since reset release
    int mval   = 0;   // value the current frame displays

    always #5 clk = ~clk;

    display_scan_controller #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANKC), .LZ_BLANK(1)) u_lz1 (
        .clk(clk), .rst(rst), .binary_code(binary_code),
        .digit(digit1), .blank(blank1), .an(an1), .frame_start(fs1)
    );

    display_scan_controller #(.DWELL_CYCLES(DWELL), .BLANK_CYCLES(BLANKC), .LZ_BLANK(0)) u_lz0 (
        .clk(clk), .rst(rst), .binary_code(binary_code),
        .digit(digit0), .blank(blank0), .an(an0), .frame_start(fs0)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0d value=%0d)", tag, got, exp, t, mval);
        end
    endtask

    // Expected {frame_start, blank, an[1:0], digit[3:0]} from the frame position.
    function automatic logic [7:0] expect_out(input int lz);
        int p;
        int tens;
        int units;
        p     = t % PERIOD;
        tens  = mval / 10;
        units = mval % 10;
        if (p >= BLANKC && p < BLANKC + DWELL)
            return {(p == BLANKC) ? 1'b1 : 1'b0, 1'b0, 2'b10, 4'(units)};
        if (p >= 2 * BLANKC + DWELL) begin
            if (tens == 0 && lz != 0) return 8'b0111_0000;
            return {1'b0, 1'b0, 2'b01, 4'(tens)};
        end
        return 8'b0111_0000;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_lz1"}, {fs1, blank1, an1, digit1}, expect_out(1));
        check({tag, "_lz0"}, {fs0, blank0, an0, digit0}, expect_out(0));
        check({tag, "_an_nz"}, {6'd0, an1 == 2'b00, an0 == 2'b00}, 8'd0);
    endtask

    task automatic model_edge();
        if (!rst) begin
            t++;
            if (t % PERIOD == BLANKC) mval = int'(binary_code);
        end
    endtask

    // One clock: check the current cycle, drive the next input, take the edge.
    task automatic cycle(input string tag, input logic [3:0] code);
        @(negedge clk);
        check_all(tag);
        binary_code = code;
        @(posedge clk);
        model_edge();
    endtask

    // Asynchronous reset between edges, held over two edges, released mid-cycle.
    task automatic async_reset(input logic [3:0] code);
        @(posedge clk);
        model_edge();
        #3 rst = 1'b1;
        #1;
        t = 0;
        mval = 0;
        check("async_rst_lz1", {fs1, blank1, an1, digit1}, 8'b0111_0000);
        check("async_rst_lz0", {fs0, blank0, an0, digit0}, 8'b0111_0000);
        repeat (2) begin
            @(negedge clk);
            check_all("rst_hold");
        end
        binary_code = code;
        rst = 1'b0;
        @(posedge clk);
        model_edge();
    endtask

    initial begin
        // Reset state and first frame with 7
        repeat (2) begin
            @(negedge clk);
            check_all("reset");
        end
        binary_code = 4'd7;
        rst = 1'b0;
        @(posedge clk);
        model_edge();
        for (int i = 0; i < 2 * PERIOD; i++) cycle("val7", 4'd7);

        async_reset(4'd13);
        for (int i = 0; i < PERIOD; i++) cycle("val13", 4'd13);

        async_reset(4'd4);
        for (int i = 0; i < PERIOD; i++) cycle("val4", 4'd4);

        // Input changes mid SHOW_UNITS: frame keeps 5, next frame shows 12
        async_reset(4'd5);
        for (int i = 0; i < 4; i++) cycle("mid5", 4'd5);
        for (int i = 0; i < 2 * PERIOD; i++) cycle("mid12", 4'd12);

        // Reset while in SHOW_TENS
        for (int i = 0; i < PERIOD && (t % PERIOD) != 9; i++) cycle("to_tens", 4'd12);
        check("in_tens", 8'(t % PERIOD), 8'd9);
        async_reset(4'd9);
        for (int i = 0; i < PERIOD; i++) cycle("after_rst", 4'd9);

        // Sweep every value for one aligned frame each
        async_reset(4'd0);
        for (int v = 0; v < 16; v++)
            for (int i = 0; i < PERIOD; i++) cycle("sweep", 4'(v));

        // Random input activity with occasional mid-frame resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) async_reset(4'($urandom_range(0, 15)));
            else if ($urandom_range(0, 2) == 0) cycle("rand", 4'($urandom_range(0, 15)));
            else cycle("rand", binary_code);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Time-multiplexes one shared 7-segment decoder between two digit positions: units and tens.
- Takes the 4-bit binary value from the Gray-decoder path, which ranges 0..15, and splits it into tens (0/1) and units (0..9).
- Scans the two active-low anodes with a dwell/blank schedule.
- Sits between the Gray-to-binary stage and the shared segment decoder. It owns the "units or tens" selection for the display.

Parameters:
- DWELL_CYCLES, 27000: clock cycles a digit is driven per visit. Must be >= 1.
- BLANK_CYCLES, 16: all-anodes-off cycles between digit switches, to prevent ghosting. Must be >= 1.
- LZ_BLANK, 1: when 1, the tens digit is blanked (anode off) when tens == 0.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- binary_code  in  4  value to display, 0..15, unsigned.
- digit  out  4  BCD digit driven to the shared segment decoder.
- blank  out  1  1 = segment decoder output must be suppressed.
- an  out  2  active-low anodes: an[0] = units, an[1] = tens.
- frame_start  out  1  one-cycle pulse when a new value is latched.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high (clk, rst).

State machine, four states, cycle counter cnt:
- BLANK_TO_UNITS: lasts BLANK_CYCLES cycles, then goes to SHOW_UNITS.
- SHOW_UNITS: lasts DWELL_CYCLES cycles, then goes to BLANK_TO_TENS.
- BLANK_TO_TENS: lasts BLANK_CYCLES cycles, then goes to SHOW_TENS.
- SHOW_TENS: lasts DWELL_CYCLES cycles, then goes to BLANK_TO_UNITS.
- In every state, cnt counts 0..N-1. The transition happens on the edge where cnt == N-1, and cnt clears to 0 on that same edge.
- Frame period is 2*(DWELL_CYCLES+BLANK_CYCLES) cycles.

Reset:
- Registers: state = BLANK_TO_UNITS, cnt = 0, value_q = 0.
- Outputs: an = 2'b11, blank = 1, digit = 0, frame_start = 0.
- Assertion of rst mid-frame forces this immediately, without waiting for clk.
- After rst deasserts, the first SHOW_UNITS is entered after exactly BLANK_CYCLES rising edges.

Value latching:
- value_q <= binary_code only on the edge that moves BLANK_TO_UNITS -> SHOW_UNITS.
- Both digits of one frame therefore always come from the same value. Changes on binary_code at any other time are invisible until the next frame start.
- frame_start = 1 exactly during the first cycle of SHOW_UNITS (cnt == 0), otherwise 0.

Digit split:
- If value_q >= 10: tens = 1, units = value_q - 10.
- Otherwise: tens = 0, units = value_q.
- Arithmetic is 4-bit unsigned; no other values are possible.

Outputs:
- Outputs are a pure function of the registered state, cnt and value_q. There is no combinational path from binary_code to any output.
- BLANK states: an = 2'b11, blank = 1, digit = 0.
- SHOW_UNITS: an = 2'b10, blank = 0, digit = units.
- SHOW_TENS with tens == 1, or with LZ_BLANK == 0: an = 2'b01, blank = 0, digit = {3'b000, tens}.
- SHOW_TENS with tens == 0 and LZ_BLANK == 1: an = 2'b11, blank = 1, digit = 0. Timing is unchanged; the slot is still consumed.

Invariants:
- At most one anode is low in any cycle.
- an and digit never change in the same cycle that a different anode turns on, because a blank state always separates digit visits.

Test Plan:
Use DWELL_CYCLES = 4 and BLANK_CYCLES = 2 for all scenarios.
1. Reset, then release with binary_code = 7, LZ_BLANK = 1.
   - Cycles 0-1: an = 11.
   - Cycles 2-5: an = 10, digit = 7, frame_start high in cycle 2 only.
   - Cycles 6-7: an = 11.
   - Cycles 8-11: an = 11, blank = 1.
   - Period is 12 cycles.
2. binary_code = 13.
   - SHOW_UNITS: an = 10, digit = 3.
   - SHOW_TENS: an = 01, digit = 1, blank = 0.
3. LZ_BLANK = 0, binary_code = 4.
   - SHOW_TENS: an = 01, digit = 0, blank = 0.
4. binary_code switches 5 -> 12 in the middle of SHOW_UNITS.
   - Rest of the frame still shows units 5 and tens blanked.
   - Next frame shows 2 / 1.
   - frame_start pulses once per 12 cycles.
5. Assert rst during SHOW_TENS, asynchronously and between edges.
   - Outputs go to an = 11, blank = 1, digit = 0 immediately.
   - After release, the first SHOW_UNITS comes after 2 edges with the value re-latched.
6. Sweep binary_code over 0..15 for one frame each.
   - Check units/tens for every value: 0..9 gives tens = 0; 10..15 gives tens = 1, units = 0..5.
   - Assert an != 2'b00 every cycle.
